serial_adder: RTL
=================

Name: serial_adder

Overview:
- Parametrised bit-serial adder, the sequential successor of the team's half/full adder cells.
- Adds two WIDTH-bit operands plus carry-in, one bit per clock, LSB first, through a single full-adder slice and a carry flop.
- Start/busy/done handshake; registered result.
- Serves as the small sequential DUT for the DFT flow: scan insertion, stuck-at pattern targets and at-speed capture.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH), bit-cycle counter width; derived, not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset; one clock, no other reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  single-cycle pulse; result valid.
- sum  output  WIDTH  registered sum; holds until the next completion.
- cout  output  1  registered carry-out; holds until the next completion.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, count=0, carry=0, a_sr=b_sr=sum_sr=0, sum=0, cout=0, busy=0, done=0. All flops clear immediately, without waiting for a clock edge.
- FSM states: IDLE, RUN, DONE. Encoding is 2 bits; the fourth code returns to IDLE on the next edge.
- IDLE, start=1 at an edge:
  - a_sr<=a, b_sr<=b, carry<=cin, count<=0, sum_sr<=0.
  - Next state RUN.
- IDLE, start=0: no change.
- RUN, every edge:
  - s = a_sr[0]^b_sr[0]^carry.
  - carry <= majority(a_sr[0], b_sr[0], carry).
  - a_sr and b_sr shift right, zero-filled.
  - sum_sr <= {s, sum_sr[WIDTH-1:1]}.
  - count <= count+1.
- RUN with count==WIDTH-1:
  - Final bit is computed as above.
  - sum <= {s, sum_sr[WIDTH-1:1]}, cout <= majority result.
  - Next state DONE.
- DONE: done=1 for exactly one cycle; next edge goes to IDLE unconditionally.
- start is ignored in RUN and in DONE. No queuing.
- start held high continuously: a new operation is accepted on the first edge in IDLE, i.e. back-to-back ops every WIDTH+2 edges.
- Latency:
  - done rises after WIDTH edges following the accepting edge.
  - The next start is accepted 2 edges after that.
- busy and done are decoded from state registers only; no combinational path from any input.
- a, b and cin may change freely after the accepting edge.
- Reset during RUN or DONE aborts the operation. sum/cout clear to 0 and no done is issued.
- Arithmetic: {cout,sum} = a+b+cin modulo 2^(WIDTH+1), exact for all inputs.

Optional Feature:
- Macro: SERIAL_ADDER_SCAN_EN.
- Defined: adds ports scan_en (input, 1), scan_in (input, 1) and scan_out (output, 1).
  - With scan_en=1, every flop forms one shift chain and the FSM/datapath update is suppressed.
  - Chain order: scan_in -> state[1:0] -> count[CNT_W-1:0] -> carry -> a_sr[WIDTH-1:0] -> b_sr -> sum_sr -> sum -> cout -> scan_out.
  - Chain length is 2+CNT_W+1+4*WIDTH+1.
  - Each vector's bits are taken MSB first.
  - With scan_en=0, behaviour is identical to the non-macro build.
  - rst_n overrides scan.
- Undefined: none of these ports or muxes exist.

Test Plan:
- Reset check: rst_n low mid-clock -> all outputs 0 immediately; start held low -> stays IDLE with busy=0.
- Basic add: WIDTH=8, a=8'h03, b=8'h05, cin=0, start 1 cycle -> busy high 8 cycles, done pulse on the 8th edge after acceptance, sum=8'h08, cout=0.
- Carry propagation:
  - a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1.
  - a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1.
- Handshake: a second start pulse with a=8'h11 during RUN and another during DONE -> both ignored, result from the first op only, exactly one done.
- Reset mid-op: rst_n low on edge 4 of RUN -> IDLE, sum=0, cout=0, no done. A new op a=8'h10, b=8'h20 then gives sum=8'h30.
- Scan (with SERIAL_ADDER_SCAN_EN, WIDTH=8): scan_en=1, shift a 39-bit pattern in -> the same pattern appears on scan_out after 39 more shifts, and state/counter do not advance while scan_en=1.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice and a carry flop, LSB first.
// Optional scan chain over every flop when SERIAL_ADDER_SCAN_EN is defined.
module serial_adder #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_SCAN_EN
  ,
  input  logic             scan_en,
  input  logic             scan_in,
  output logic             scan_out
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       r_state, w_state_nxt, w_state_d;
  logic [CNT_W-1:0] r_count, w_count_nxt, w_count_d;
  logic             r_carry, w_carry_nxt, w_carry_d;
  logic [WIDTH-1:0] r_a, w_a_nxt, w_a_d;
  logic [WIDTH-1:0] r_b, w_b_nxt, w_b_d;
  logic [WIDTH-1:0] r_sum_sr, w_sum_sr_nxt, w_sum_sr_d;
  logic [WIDTH-1:0] r_sum, w_sum_nxt, w_sum_d;
  logic             r_cout, w_cout_nxt, w_cout_d;
  logic             w_s, w_maj, w_last;

  assign w_s    = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_maj  = (r_a[0] & r_b[0]) | (r_a[0] & r_carry)
                | (r_b[0] & r_carry);
  assign w_last = (r_count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_d;
  end

  // DONE and the unused code both fall back to IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_RUN);
    done = (r_state == S_DONE);
  end

  always_comb begin
    w_count_nxt  = r_count;
    w_carry_nxt  = r_carry;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_sum_sr_nxt = r_sum_sr;
    w_sum_nxt    = r_sum;
    w_cout_nxt   = r_cout;
    if (r_state == S_IDLE && start) begin
      w_a_nxt      = a;
      w_b_nxt      = b;
      w_carry_nxt  = cin;
      w_count_nxt  = '0;
      w_sum_sr_nxt = '0;
    end else if (r_state == S_RUN) begin
      w_carry_nxt  = w_maj;
      w_a_nxt      = {1'b0, r_a[WIDTH-1:1]};
      w_b_nxt      = {1'b0, r_b[WIDTH-1:1]};
      w_sum_sr_nxt = {w_s, r_sum_sr[WIDTH-1:1]};
      w_count_nxt  = r_count + 1'b1;
      if (w_last) begin
        w_sum_nxt  = {w_s, r_sum_sr[WIDTH-1:1]};
        w_cout_nxt = w_maj;
      end
    end
  end

`ifdef SERIAL_ADDER_SCAN_EN
  localparam int CHAIN_W = 2 + CNT_W + 1 + 4 * WIDTH + 1;

  // Chain minus its tail flop (cout), which drives scan_out directly
  logic [CHAIN_W-2:0] w_chain;
  assign w_chain  = {r_state, r_count, r_carry, r_a, r_b,
                     r_sum_sr, r_sum};
  assign scan_out = r_cout;

  assign {w_state_d, w_count_d, w_carry_d, w_a_d, w_b_d,
          w_sum_sr_d, w_sum_d, w_cout_d} =
    scan_en ? {scan_in, w_chain}
            : {w_state_nxt, w_count_nxt, w_carry_nxt, w_a_nxt,
               w_b_nxt, w_sum_sr_nxt, w_sum_nxt, w_cout_nxt};
`else
  assign {w_state_d, w_count_d, w_carry_d, w_a_d, w_b_d,
          w_sum_sr_d, w_sum_d, w_cout_d} =
    {w_state_nxt, w_count_nxt, w_carry_nxt, w_a_nxt,
     w_b_nxt, w_sum_sr_nxt, w_sum_nxt, w_cout_nxt};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_carry  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_sum_sr <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
    end else begin
      r_count  <= w_count_d;
      r_carry  <= w_carry_d;
      r_a      <= w_a_d;
      r_b      <= w_b_d;
      r_sum_sr <= w_sum_sr_d;
      r_sum    <= w_sum_d;
      r_cout   <= w_cout_d;
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule
